hazard_fwd_unit: RTL and testbench
==================================

Name: hazard_fwd_unit

Overview:
- Parametrised successor of the pipeline forwarding logic for the segmented RISC-V core.
- Keeps an internal shadow pipeline of in-flight register writers (MEM..WB and beyond) and produces operand forwarding selects for EX and write-through bypass for RR.
- Detects load-use hazards and holds a multi-cycle stall via a counter; honours x0, write-enables and branch flush, none of which the previous generation handled.

Parameters:
- REG_AW, 5, register address width.
- NUM_SRC, 2, source operands per instruction.
- FWD_STAGES, 2, forwarding stages after EX (1=MEM, 2=WB, ...); must be >= LOAD_LAT+1.
- LOAD_LAT, 1, stall cycles required between a load in EX and a dependent instruction in RR; must be >= 1.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- ex_valid_i  in  1  EX holds a real instruction (not a bubble).
- ex_rd_i  in  REG_AW  EX destination register.
- ex_we_i  in  1  EX instruction writes rd.
- ex_load_i  in  1  EX instruction is a load.
- ex_rs_i  in  NUM_SRC*REG_AW  EX source registers; operand n is slice n.
- ex_use_i  in  NUM_SRC  EX operand n reads a register (R-type/branch for rs2).
- rr_rs_i  in  NUM_SRC*REG_AW  RR-stage source registers.
- rr_use_i  in  NUM_SRC  RR operand n reads a register.
- flush_i  in  1  taken branch; kill the younger instructions (RR and EX).
- fwd_sel_o  out  NUM_SRC*SELW  EX operand mux select, SELW = clog2(FWD_STAGES+1). 0 = register file, k = shadow stage k.
- rr_bypass_o  out  NUM_SRC  RR operand takes the stage-FWD_STAGES (WB) write data.
- stall_o  out  1  hold PC/IF/RR this cycle.
- bubble_o  out  1  inject a bubble into EX next cycle (equals stall_o & ~flush_i).

Behaviour:
- Reset: shadow entries cleared (we=0, rd=0, load=0), stall counter 0. With no inputs active, all outputs read 0.
- Shadow pipeline: FWD_STAGES entries of {rd, we, load}, shifted every cycle regardless of stall.
  - Stage 1 captures {ex_rd_i, ex_we_i & ex_valid_i & (ex_rd_i!=0), ex_load_i}.
  - flush_i does not affect the capture: the instruction in EX is older than the branch's victims, and the pipeline itself clears EX.
- Forwarding (combinational from the shadow stages):
  - For each n with ex_use_i[n] and rs!=0, select the lowest k whose entry has we=1 and rd==rs. The youngest writer wins.
  - Otherwise select 0. If ex_use_i[n]=0, select 0.
  - A load entry at k <= LOAD_LAT never matches; the stall guarantees this case does not occur.
- RR bypass: rr_bypass_o[n]=1 iff rr_use_i[n], rr_rs!=0, stage FWD_STAGES has we=1, and rd==rr_rs. This is same-cycle register-file write-through.
- Load-use detect: hz = ex_valid_i & ex_load_i & ex_we_i & ex_rd_i!=0 & any n (rr_use_i[n] & rr_rs[n]==ex_rd_i).
- Stall counter:
  - If flush_i: cnt <= 0.
  - Else if hz & cnt==0: cnt <= LOAD_LAT-1.
  - Else if cnt!=0: cnt <= cnt-1.
- stall_o = ~flush_i & (hz | cnt!=0). The stall length is exactly LOAD_LAT cycles per hazard.
- hz is not re-evaluated while cnt!=0; the load has left EX by then.
- Simultaneous flush and hazard: flush wins; no stall and no bubble.
- Reset asserted mid-stall: counter and shadow cleared immediately, stall_o drops asynchronously.
- Latency: forwarding and bypass are 0-cycle combinational; the shadow has 1-cycle capture.

Decomposition:
- hazard_pkg holds:
  - REG_AW default;
  - FWD_SEL_RF=0 and FWD_SEL_MEM=1, FWD_SEL_WB=2 constants;
  - a typedef for shadow entry {rd, we, load}.
- One sub-module, hz_shadow_pipe, implements the FWD_STAGES-deep shift register with reset.
- Priority match, detect logic and the counter stay in the top level.

Test Plan:
- Defaults. Cycle 0: EX `add x5` (we=1). Cycle 1: EX uses rs1=x5 -> fwd_sel[0]=1. Cycle 2: EX uses rs2=x5 with ex_use_i[1]=1 -> fwd_sel[1]=2.
- Same-register priority. x5 is written in both stages 1 and 2 -> fwd_sel=1. A writer to x0 followed by a reader of x0 -> fwd_sel=0, rr_bypass=0.
- Load-use, LOAD_LAT=1. EX `lw x7`, RR uses x7 -> stall_o=1 and bubble_o=1 for 1 cycle. Next cycle the load is at stage 1 with an EX bubble. The cycle after, EX reads x7 -> fwd_sel=2.
- LOAD_LAT=3, FWD_STAGES=4 -> stall_o held exactly 3 cycles. A flush_i pulse in stall cycle 2 -> stall_o=0 that cycle and cnt cleared.
- WB write-through. Stage 2 entry x9 we=1 while RR reads rs1=x9 -> rr_bypass_o[0]=1. Same stimulus with we=0 -> 0.
- rst_n pulled low during a LOAD_LAT=3 stall -> stall_o=0 immediately, all fwd_sel 0 after release.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared constants and the shadow-entry type for the hazard/forwarding unit.
package hazard_pkg;
    localparam int REG_AW_DEF  = 5;
    localparam int FWD_SEL_RF  = 0;
    localparam int FWD_SEL_MEM = 1;
    localparam int FWD_SEL_WB  = 2;

    typedef struct packed {
        logic [REG_AW_DEF-1:0] rd;
        logic                  we;
        logic                  load;
    } shadow_ent_t;
endpackage

// File: rtl/hazard_fwd_unit_if.sv
// Pipeline-side signal bundle of the hazard/forwarding unit.
interface hazard_fwd_unit_if #(
    parameter int REG_AW     = 5,
    parameter int NUM_SRC    = 2,
    parameter int FWD_STAGES = 2
);
    localparam int SELW = $clog2(FWD_STAGES + 1);

    logic                      ex_valid_i;
    logic [REG_AW-1:0]         ex_rd_i;
    logic                      ex_we_i;
    logic                      ex_load_i;
    logic [NUM_SRC*REG_AW-1:0] ex_rs_i;
    logic [NUM_SRC-1:0]        ex_use_i;
    logic [NUM_SRC*REG_AW-1:0] rr_rs_i;
    logic [NUM_SRC-1:0]        rr_use_i;
    logic                      flush_i;
    logic [NUM_SRC*SELW-1:0]   fwd_sel_o;
    logic [NUM_SRC-1:0]        rr_bypass_o;
    logic                      stall_o;
    logic                      bubble_o;

    modport master (
        output ex_valid_i, ex_rd_i, ex_we_i, ex_load_i, ex_rs_i, ex_use_i,
        output rr_rs_i, rr_use_i, flush_i,
        input  fwd_sel_o, rr_bypass_o, stall_o, bubble_o
    );

    modport slave (
        input  ex_valid_i, ex_rd_i, ex_we_i, ex_load_i, ex_rs_i, ex_use_i,
        input  rr_rs_i, rr_use_i, flush_i,
        output fwd_sel_o, rr_bypass_o, stall_o, bubble_o
    );
endinterface

// File: rtl/hz_shadow_pipe.sv
// Shift register of in-flight register writers; stage 1 is MEM, stage FWD_STAGES is WB.
module hz_shadow_pipe
    import hazard_pkg::*;
#(
    parameter int FWD_STAGES = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  shadow_ent_t                  cap,
    output shadow_ent_t [FWD_STAGES:1]   stg
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg <= '0;
        end else begin
            stg[1] <= cap;
            for (int k = 2; k <= FWD_STAGES; k++) begin
                stg[k] <= stg[k-1];
            end
        end
    end

endmodule

// File: rtl/hazard_fwd_unit.sv
// Operand forwarding selects for EX, WB write-through for RR, and load-use stall control.
module hazard_fwd_unit
    import hazard_pkg::*;
#(
    parameter int REG_AW     = REG_AW_DEF,
    parameter int NUM_SRC    = 2,
    parameter int FWD_STAGES = 2,
    parameter int LOAD_LAT   = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    hazard_fwd_unit_if.slave bus
);

    localparam int SELW  = $clog2(FWD_STAGES + 1);
    localparam int CNT_W = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;

    shadow_ent_t                cap;
    shadow_ent_t [FWD_STAGES:1] stg;
    logic [NUM_SRC*SELW-1:0]    fwd;
    logic [NUM_SRC-1:0]         byp;
    logic                       hz;
    logic [CNT_W-1:0]           cnt;
    logic                       stall;

    // Capture at EX -> stage 1; writes to x0 and bubbles never become forwarding sources
    always_comb begin
        cap.rd   = bus.ex_rd_i;
        cap.we   = bus.ex_we_i & bus.ex_valid_i & (bus.ex_rd_i != '0);
        cap.load = bus.ex_load_i;
    end

    hz_shadow_pipe #(.FWD_STAGES(FWD_STAGES)) u_shadow (
        .clk   (clk),
        .rst_n (rst_n),
        .cap   (cap),
        .stg   (stg)
    );

    // Scan oldest to youngest so the youngest matching writer is the last to assign
    always_comb begin
        logic [REG_AW-1:0] rs;
        logic [SELW-1:0]   sel;
        fwd = '0;
        for (int n = 0; n < NUM_SRC; n++) begin
            rs  = bus.ex_rs_i[n*REG_AW +: REG_AW];
            sel = SELW'(FWD_SEL_RF);
            if (bus.ex_use_i[n] && rs != '0) begin
                for (int k = FWD_STAGES; k >= 1; k--) begin
                    if (stg[k].we && stg[k].rd == rs && !(stg[k].load && k <= LOAD_LAT))
                        sel = SELW'(k);
                end
            end
            fwd[n*SELW +: SELW] = sel;
        end
    end

    always_comb begin
        logic [REG_AW-1:0] rs;
        byp = '0;
        for (int n = 0; n < NUM_SRC; n++) begin
            rs     = bus.rr_rs_i[n*REG_AW +: REG_AW];
            byp[n] = bus.rr_use_i[n] && rs != '0 && stg[FWD_STAGES].we &&
                     stg[FWD_STAGES].rd == rs;
        end
    end

    always_comb begin
        hz = 1'b0;
        if (bus.ex_valid_i && bus.ex_load_i && bus.ex_we_i && bus.ex_rd_i != '0) begin
            for (int n = 0; n < NUM_SRC; n++) begin
                if (bus.rr_use_i[n] && bus.rr_rs_i[n*REG_AW +: REG_AW] == bus.ex_rd_i)
                    hz = 1'b1;
            end
        end
    end

    // The first stall cycle comes from hz itself; the counter covers the remaining LOAD_LAT-1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (bus.flush_i) begin
            cnt <= '0;
        end else if (hz && cnt == '0) begin
            cnt <= CNT_W'(LOAD_LAT - 1);
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign stall           = ~bus.flush_i & (hz | (cnt != '0));
    assign bus.stall_o     = stall;
    assign bus.bubble_o    = stall & ~bus.flush_i;
    assign bus.fwd_sel_o   = fwd;
    assign bus.rr_bypass_o = byp;

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Bench for hazard_fwd_unit: DUT A (FWD_STAGES=2, LOAD_LAT=1), DUT B (FWD_STAGES=4, LOAD_LAT=3).
module tb_hazard_fwd_unit;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    hazard_fwd_unit_if #(.REG_AW(5), .NUM_SRC(2), .FWD_STAGES(2)) bus_a ();
    hazard_fwd_unit_if #(.REG_AW(5), .NUM_SRC(2), .FWD_STAGES(4)) bus_b ();

    hazard_fwd_unit #(.REG_AW(5), .NUM_SRC(2), .FWD_STAGES(2), .LOAD_LAT(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a.slave));
    hazard_fwd_unit #(.REG_AW(5), .NUM_SRC(2), .FWD_STAGES(4), .LOAD_LAT(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b.slave));

    // Reference model: history of EX instructions by age, plus outstanding stall cycles
    logic       t_exv [2], t_exw [2], t_exl [2], t_fl [2];
    logic [4:0] t_exrd [2];
    logic [9:0] t_exrs [2], t_rrs [2];
    logic [1:0] t_use [2], t_ruse [2];

    assign t_exv[0] = bus_a.ex_valid_i;  assign t_exv[1] = bus_b.ex_valid_i;
    assign t_exw[0] = bus_a.ex_we_i;     assign t_exw[1] = bus_b.ex_we_i;
    assign t_exl[0] = bus_a.ex_load_i;   assign t_exl[1] = bus_b.ex_load_i;
    assign t_fl[0]  = bus_a.flush_i;     assign t_fl[1]  = bus_b.flush_i;
    assign t_exrd[0] = bus_a.ex_rd_i;    assign t_exrd[1] = bus_b.ex_rd_i;
    assign t_exrs[0] = bus_a.ex_rs_i;    assign t_exrs[1] = bus_b.ex_rs_i;
    assign t_rrs[0]  = bus_a.rr_rs_i;    assign t_rrs[1]  = bus_b.rr_rs_i;
    assign t_use[0]  = bus_a.ex_use_i;   assign t_use[1]  = bus_b.ex_use_i;
    assign t_ruse[0] = bus_a.rr_use_i;   assign t_ruse[1] = bus_b.rr_use_i;

    logic [4:0] h_rd [2][1:4];
    logic       h_we [2][1:4];
    logic       h_ld [2][1:4];
    int         rem  [2];

    function automatic int fs(int d); return (d == 0) ? 2 : 4; endfunction
    function automatic int ll(int d); return (d == 0) ? 1 : 3; endfunction

    function automatic logic exp_hz(int d);
        logic h = 1'b0;
        if (t_exv[d] && t_exl[d] && t_exw[d] && t_exrd[d] != 5'd0)
            for (int n = 0; n < 2; n++)
                if (t_ruse[d][n] && t_rrs[d][n*5 +: 5] == t_exrd[d]) h = 1'b1;
        return h;
    endfunction

    function automatic logic exp_stall(int d);
        return !t_fl[d] && (exp_hz(d) || rem[d] != 0);
    endfunction

    function automatic logic [5:0] exp_fwd(int d);
        logic [5:0] r = '0;
        int selw = (d == 0) ? 2 : 3;
        for (int n = 0; n < 2; n++) begin
            logic [4:0] rs = t_exrs[d][n*5 +: 5];
            int found = 0;
            if (t_use[d][n] && rs != 5'd0)
                for (int age = 1; age <= fs(d); age++)
                    if (found == 0 && h_we[d][age] && h_rd[d][age] == rs &&
                        !(h_ld[d][age] && age <= ll(d)))
                        found = age;
            r = r | (6'(found) << (n * selw));
        end
        return r;
    endfunction

    function automatic logic [1:0] exp_byp(int d);
        logic [1:0] r = '0;
        for (int n = 0; n < 2; n++) begin
            logic [4:0] rs = t_rrs[d][n*5 +: 5];
            r[n] = t_ruse[d][n] && rs != 5'd0 && h_we[d][fs(d)] && h_rd[d][fs(d)] == rs;
        end
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                rem[d] <= 0;
                for (int k = 1; k <= 4; k++) begin
                    h_rd[d][k] <= '0; h_we[d][k] <= 1'b0; h_ld[d][k] <= 1'b0;
                end
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (t_fl[d])                        rem[d] <= 0;
                else if (exp_hz(d) && rem[d] == 0)  rem[d] <= ll(d) - 1;
                else if (rem[d] > 0)                rem[d] <= rem[d] - 1;
                h_rd[d][1] <= t_exrd[d];
                h_we[d][1] <= t_exv[d] && t_exw[d] && t_exrd[d] != 5'd0;
                h_ld[d][1] <= t_exl[d];
                for (int k = 2; k <= 4; k++) begin
                    h_rd[d][k] <= h_rd[d][k-1]; h_we[d][k] <= h_we[d][k-1]; h_ld[d][k] <= h_ld[d][k-1];
                end
            end
        end
    end

    task automatic drive(input int d, input logic v, input logic [4:0] rd, input logic we,
                         input logic ld, input logic [9:0] rs, input logic [1:0] u,
                         input logic [9:0] rrs, input logic [1:0] ru, input logic fl);
        if (d == 0) begin
            bus_a.ex_valid_i = v; bus_a.ex_rd_i = rd; bus_a.ex_we_i = we; bus_a.ex_load_i = ld;
            bus_a.ex_rs_i = rs; bus_a.ex_use_i = u; bus_a.rr_rs_i = rrs; bus_a.rr_use_i = ru;
            bus_a.flush_i = fl;
        end else begin
            bus_b.ex_valid_i = v; bus_b.ex_rd_i = rd; bus_b.ex_we_i = we; bus_b.ex_load_i = ld;
            bus_b.ex_rs_i = rs; bus_b.ex_use_i = u; bus_b.rr_rs_i = rrs; bus_b.rr_use_i = ru;
            bus_b.flush_i = fl;
        end
    endtask

    task automatic idle_all();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        idle_all();
        repeat (5) advance();
    endtask

    task automatic test_reset();
        idle_all();
        @(negedge clk);
        vectors++;
        if ({bus_a.fwd_sel_o, bus_a.rr_bypass_o, bus_a.stall_o, bus_a.bubble_o} !== 8'd0) begin
            miscompares++;
            $display("FAIL reset_a: got fwd=%b byp=%b stall=%b bubble=%b want all 0",
                     bus_a.fwd_sel_o, bus_a.rr_bypass_o, bus_a.stall_o, bus_a.bubble_o);
        end
        vectors++;
        if ({bus_b.fwd_sel_o, bus_b.rr_bypass_o, bus_b.stall_o, bus_b.bubble_o} !== 10'd0) begin
            miscompares++;
            $display("FAIL reset_b: got fwd=%b byp=%b stall=%b bubble=%b want all 0",
                     bus_b.fwd_sel_o, bus_b.rr_bypass_o, bus_b.stall_o, bus_b.bubble_o);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        settle();
    endtask

    task automatic test_fwd_basic();
        settle();
        drive(0, 1, 5'd5, 1, 0, 0, 0, 0, 0, 0);
        advance();
        drive(0, 1, 5'd0, 0, 0, {5'd0, 5'd5}, 2'b01, 0, 0, 0);
        @(negedge clk);
        vectors++;
        if (bus_a.fwd_sel_o !== 4'b0001) begin
            miscompares++;
            $display("FAIL fwd_mem_rs1: got %b want 0001", bus_a.fwd_sel_o);
        end
        advance();
        drive(0, 1, 5'd0, 0, 0, {5'd5, 5'd0}, 2'b10, 0, 0, 0);
        @(negedge clk);
        vectors++;
        if (bus_a.fwd_sel_o !== 4'b1000) begin
            miscompares++;
            $display("FAIL fwd_wb_rs2: got %b want 1000", bus_a.fwd_sel_o);
        end
        advance();
        drive(0, 1, 5'd0, 0, 0, {5'd5, 5'd0}, 2'b00, 0, 0, 0);
        @(negedge clk);
        vectors++;
        if (bus_a.fwd_sel_o !== 4'b0000) begin
            miscompares++;
            $display("FAIL fwd_unused: got %b want 0000", bus_a.fwd_sel_o);
        end
        advance();
    endtask

    task automatic test_priority();
        settle();
        drive(0, 1, 5'd5, 1, 0, 0, 0, 0, 0, 0);
        advance();
        drive(0, 1, 5'd5, 1, 0, 0, 0, 0, 0, 0);
        advance();
        drive(0, 1, 5'd0, 0, 0, {5'd5, 5'd5}, 2'b11, 0, 0, 0);
        @(negedge clk);
        vectors++;
        if (bus_a.fwd_sel_o !== 4'b0101) begin
            miscompares++;
            $display("FAIL fwd_youngest: got %b want 0101", bus_a.fwd_sel_o);
        end
        advance();
        drive(0, 1, 5'd0, 1, 0, 0, 0, 0, 0, 0);
        advance();
        drive(0, 1, 5'd0, 0, 0, {5'd0, 5'd0}, 2'b01, {5'd0, 5'd0}, 2'b01, 0);
        @(negedge clk);
        vectors++;
        if (bus_a.fwd_sel_o !== 4'b0000) begin
            miscompares++;
            $display("FAIL fwd_x0: got %b want 0000", bus_a.fwd_sel_o);
        end
        advance();
        @(negedge clk);
        vectors++;
        if (bus_a.rr_bypass_o !== 2'b00) begin
            miscompares++;
            $display("FAIL bypass_x0: got %b want 00", bus_a.rr_bypass_o);
        end
        advance();
    endtask

    task automatic test_load_use();
        settle();
        drive(0, 1, 5'd7, 1, 1, 0, 0, {5'd0, 5'd7}, 2'b01, 0);
        @(negedge clk);
        vectors++;
        if ({bus_a.stall_o, bus_a.bubble_o} !== 2'b11) begin
            miscompares++;
            $display("FAIL load_use_stall: got stall=%b bubble=%b want 1 1", bus_a.stall_o, bus_a.bubble_o);
        end
        advance();
        drive(0, 0, 5'd0, 0, 0, 0, 0, {5'd0, 5'd7}, 2'b01, 0);
        @(negedge clk);
        vectors++;
        if ({bus_a.stall_o, bus_a.bubble_o} !== 2'b00) begin
            miscompares++;
            $display("FAIL load_use_release: got stall=%b bubble=%b want 0 0", bus_a.stall_o, bus_a.bubble_o);
        end
        advance();
        drive(0, 1, 5'd0, 0, 0, {5'd0, 5'd7}, 2'b01, 0, 0, 0);
        @(negedge clk);
        vectors++;
        if (bus_a.fwd_sel_o !== 4'b0010) begin
            miscompares++;
            $display("FAIL load_fwd_wb: got %b want 0010", bus_a.fwd_sel_o);
        end
        advance();
        drive(0, 1, 5'd7, 1, 1, 0, 0, {5'd7, 5'd0}, 2'b10, 1);
        @(negedge clk);
        vectors++;
        if ({bus_a.stall_o, bus_a.bubble_o} !== 2'b00) begin
            miscompares++;
            $display("FAIL flush_beats_hz: got stall=%b bubble=%b want 0 0", bus_a.stall_o, bus_a.bubble_o);
        end
        advance();
    endtask

    task automatic test_long_stall();
        logic [2:0] want_stall;
        settle();
        want_stall = 3'b111;
        drive(1, 1, 5'd7, 1, 1, 0, 0, {5'd0, 5'd7}, 2'b01, 0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            vectors++;
            if (bus_b.stall_o !== (c < 3) || bus_b.bubble_o !== (c < 3)) begin
                miscompares++;
                $display("FAIL long_stall_c%0d: got stall=%b bubble=%b want %0d", c,
                         bus_b.stall_o, bus_b.bubble_o, (c < 3));
            end
            advance();
            if (c < 2) drive(1, 0, 5'd0, 0, 0, 0, 0, {5'd0, 5'd7}, 2'b01, 0);
            else       drive(1, 1, 5'd0, 0, 0, {5'd0, 5'd7}, 2'b01, 0, 0, 0);
        end
        @(negedge clk);
        vectors++;
        if (bus_b.fwd_sel_o !== 6'b000100) begin
            miscompares++;
            $display("FAIL long_load_fwd: got %b want 000100", bus_b.fwd_sel_o);
        end
        advance();
        settle();
        drive(1, 1, 5'd7, 1, 1, 0, 0, {5'd0, 5'd7}, 2'b01, 0);
        advance();
        drive(1, 0, 5'd0, 0, 0, 0, 0, {5'd0, 5'd7}, 2'b01, 1);
        @(negedge clk);
        vectors++;
        if ({bus_b.stall_o, bus_b.bubble_o} !== 2'b00) begin
            miscompares++;
            $display("FAIL flush_mid_stall: got stall=%b bubble=%b want 0 0", bus_b.stall_o, bus_b.bubble_o);
        end
        advance();
        drive(1, 0, 5'd0, 0, 0, 0, 0, {5'd0, 5'd7}, 2'b01, 0);
        @(negedge clk);
        vectors++;
        if (bus_b.stall_o !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_clears_cnt: got stall=%b want 0", bus_b.stall_o);
        end
        advance();
        if (want_stall == 3'b000) $display("unreachable");
    endtask

    task automatic test_wb_bypass();
        settle();
        drive(0, 1, 5'd9, 1, 0, 0, 0, 0, 0, 0);
        advance();
        drive(0, 0, 5'd0, 0, 0, 0, 0, 0, 0, 0);
        advance();
        drive(0, 0, 5'd0, 0, 0, 0, 0, {5'd0, 5'd9}, 2'b01, 0);
        @(negedge clk);
        vectors++;
        if (bus_a.rr_bypass_o !== 2'b01) begin
            miscompares++;
            $display("FAIL wb_bypass_we1: got %b want 01", bus_a.rr_bypass_o);
        end
        advance();
        settle();
        drive(0, 1, 5'd9, 0, 0, 0, 0, 0, 0, 0);
        advance();
        drive(0, 0, 5'd0, 0, 0, 0, 0, 0, 0, 0);
        advance();
        drive(0, 0, 5'd0, 0, 0, 0, 0, {5'd0, 5'd9}, 2'b01, 0);
        @(negedge clk);
        vectors++;
        if (bus_a.rr_bypass_o !== 2'b00) begin
            miscompares++;
            $display("FAIL wb_bypass_we0: got %b want 00", bus_a.rr_bypass_o);
        end
        advance();
    endtask

    task automatic test_reset_mid_stall();
        settle();
        drive(1, 1, 5'd7, 1, 1, 0, 0, {5'd0, 5'd7}, 2'b01, 0);
        advance();
        drive(1, 0, 5'd0, 0, 0, 0, 0, {5'd0, 5'd7}, 2'b01, 0);
        @(negedge clk);
        vectors++;
        if (bus_b.stall_o !== 1'b1) begin
            miscompares++;
            $display("FAIL pre_reset_stall: got %b want 1", bus_b.stall_o);
        end
        #1 rst_n = 1'b0;
        #1;
        vectors++;
        if ({bus_b.stall_o, bus_b.bubble_o} !== 2'b00) begin
            miscompares++;
            $display("FAIL async_reset_stall: got stall=%b bubble=%b want 0 0", bus_b.stall_o, bus_b.bubble_o);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        drive(1, 1, 5'd0, 0, 0, {5'd7, 5'd7}, 2'b11, 0, 0, 0);
        @(negedge clk);
        vectors++;
        if (bus_b.fwd_sel_o !== 6'd0 || bus_b.stall_o !== 1'b0) begin
            miscompares++;
            $display("FAIL post_reset: got fwd=%b stall=%b want 000000 0", bus_b.fwd_sel_o, bus_b.stall_o);
        end
        advance();
    endtask

    task automatic test_random();
        logic [5:0] ef;
        logic [1:0] eb;
        logic       es;
        settle();
        for (int i = 0; i < 400; i++) begin
            for (int d = 0; d < 2; d++)
                drive(d, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)),
                      {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))}, 2'($urandom),
                      {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))}, 2'($urandom),
                      ($urandom_range(0, 9) == 0));
            @(negedge clk);
            ef = exp_fwd(0); eb = exp_byp(0); es = exp_stall(0);
            vectors++;
            if (bus_a.fwd_sel_o !== ef[3:0] || bus_a.rr_bypass_o !== eb ||
                bus_a.stall_o !== es || bus_a.bubble_o !== es) begin
                miscompares++;
                $display("FAIL rand_a[%0d]: got fwd=%b byp=%b stall=%b bubble=%b want fwd=%b byp=%b stall=%b",
                         i, bus_a.fwd_sel_o, bus_a.rr_bypass_o, bus_a.stall_o, bus_a.bubble_o, ef[3:0], eb, es);
            end
            ef = exp_fwd(1); eb = exp_byp(1); es = exp_stall(1);
            vectors++;
            if (bus_b.fwd_sel_o !== ef || bus_b.rr_bypass_o !== eb ||
                bus_b.stall_o !== es || bus_b.bubble_o !== es) begin
                miscompares++;
                $display("FAIL rand_b[%0d]: got fwd=%b byp=%b stall=%b bubble=%b want fwd=%b byp=%b stall=%b",
                         i, bus_b.fwd_sel_o, bus_b.rr_bypass_o, bus_b.stall_o, bus_b.bubble_o, ef, eb, es);
            end
            advance();
        end
    endtask

    initial begin
        test_reset();
        test_fwd_basic();
        test_priority();
        test_load_use();
        test_long_stall();
        test_wb_bypass();
        test_reset_mid_stall();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
